// File: rtl/id_ex_stage_reg_if.sv
// id_ex_stage_reg_if: ID-stage inputs, EX-stage outputs and stall/flush controls of the ID/EX register.
interface id_ex_stage_reg_if #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
);
    logic [4:0]        regRSID, regRTID, regRDID;
    logic [DATA_W-1:0] readData1ID, readData2ID, immID, pcPlus4ID;
    logic              regWriteID, memReadID, memWriteID, memToRegID, branchID, aluSrcID, regDstID;
    logic [3:0]        aluOpID;
    logic              flushEX, holdEX;
    logic [4:0]        regRSEX, regRTEX, regRDEX;
    logic [DATA_W-1:0] readData1EX, readData2EX, immEX, pcPlus4EX;
    logic              regWriteEX, memReadEX, memWriteEX, memToRegEX, branchEX, aluSrcEX, regDstEX;
    logic [3:0]        aluOpEX;
    logic              stallIF;
    logic [CNT_W-1:0]  bubbleCount;

    modport master (
        output regRSID, regRTID, regRDID, readData1ID, readData2ID, immID, pcPlus4ID,
               regWriteID, memReadID, memWriteID, memToRegID, branchID, aluSrcID, regDstID,
               aluOpID, flushEX, holdEX,
        input  regRSEX, regRTEX, regRDEX, readData1EX, readData2EX, immEX, pcPlus4EX,
               regWriteEX, memReadEX, memWriteEX, memToRegEX, branchEX, aluSrcEX, regDstEX,
               aluOpEX, stallIF, bubbleCount
    );

    modport slave (
        input  regRSID, regRTID, regRDID, readData1ID, readData2ID, immID, pcPlus4ID,
               regWriteID, memReadID, memWriteID, memToRegID, branchID, aluSrcID, regDstID,
               aluOpID, flushEX, holdEX,
        output regRSEX, regRTEX, regRDEX, readData1EX, readData2EX, immEX, pcPlus4EX,
               regWriteEX, memReadEX, memWriteEX, memToRegEX, branchEX, aluSrcEX, regDstEX,
               aluOpEX, stallIF, bubbleCount
    );
endinterface

// File: rtl/id_ex_stage_reg.sv
// id_ex_stage_reg: ID/EX pipeline register with load-use bubble insertion, flush, hold and bubble counter.
module id_ex_stage_reg #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic                clk,
    input  logic                rst,
    id_ex_stage_reg_if.slave    bus
);
    localparam int PW = 15 + 4 * DATA_W;

    logic [PW-1:0]    pay_q;
    logic [10:0]      ctl_q;
    logic [CNT_W-1:0] cnt_q;
    logic             load_use;

    assign load_use = bus.memReadEX & (bus.regRTEX != 5'd0) &
                      ((bus.regRTEX == bus.regRSID) | (bus.regRTEX == bus.regRTID));
    assign bus.stallIF = (load_use & ~bus.flushEX) | bus.holdEX;

    // A load-use bubble only clears control; specifiers and data still follow ID.
    always_ff @(posedge clk) begin
        if (rst || bus.flushEX) begin
            pay_q <= '0;
            ctl_q <= '0;
        end else if (!bus.holdEX) begin
            pay_q <= {bus.regRSID, bus.regRTID, bus.regRDID,
                      bus.readData1ID, bus.readData2ID, bus.immID, bus.pcPlus4ID};
            ctl_q <= load_use ? 11'd0 :
                     {bus.regWriteID, bus.memReadID, bus.memWriteID, bus.memToRegID,
                      bus.branchID, bus.aluSrcID, bus.regDstID, bus.aluOpID};
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            cnt_q <= '0;
        else if (!bus.flushEX && !bus.holdEX && load_use && !(&cnt_q))
            cnt_q <= cnt_q + 1'b1;
    end

    assign {bus.regRSEX, bus.regRTEX, bus.regRDEX,
            bus.readData1EX, bus.readData2EX, bus.immEX, bus.pcPlus4EX} = pay_q;
    assign {bus.regWriteEX, bus.memReadEX, bus.memWriteEX, bus.memToRegEX,
            bus.branchEX, bus.aluSrcEX, bus.regDstEX, bus.aluOpEX} = ctl_q;
    assign bus.bubbleCount = cnt_q;
endmodule
